// File: rtl/dffram_arb_pkg.sv
// Shared sizing constants and FSM state type for the two-port DFFRAM arbiter.
package dffram_arb_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_SERVE = 1'b1
  } state_e;

endpackage

// File: rtl/dffram_rr_arb.sv
// Two-way round-robin arbiter: combinational grant, pointer moves to the loser after each grant.
module dffram_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr_r;

  // Grant selection; the pointer only matters under contention.
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = ptr_r ? 2'b10 : 2'b01;
    end else begin
      grant = req;
    end
  end

  // Priority pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= 1'b0;
    end else if (advance && (grant != 2'b00)) begin
      ptr_r <= grant[0];
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/dffram_arb.sv
// Two-requester front end for a single-port DFFRAM: clears the RAM after reset,
// then arbitrates one access per cycle and returns the pre-access word a cycle later.
module dffram_arb #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_valid,
  output logic                  p0_ready,
  input  logic [DATA_W/8-1:0]   p0_we,
  input  logic [ADDR_W-1:0]     p0_addr,
  input  logic [DATA_W-1:0]     p0_wdata,
  output logic                  p0_rsp_valid,
  output logic [DATA_W-1:0]     p0_rsp_rdata,
  input  logic                  p1_valid,
  output logic                  p1_ready,
  input  logic [DATA_W/8-1:0]   p1_we,
  input  logic [ADDR_W-1:0]     p1_addr,
  input  logic [DATA_W-1:0]     p1_wdata,
  output logic                  p1_rsp_valid,
  output logic [DATA_W-1:0]     p1_rsp_rdata,
  output logic                  ram_en,
  output logic [DATA_W/8-1:0]   ram_we,
  output logic [ADDR_W-1:0]     ram_a,
  output logic [DATA_W-1:0]     ram_di,
  input  logic [DATA_W-1:0]     ram_do,
  output logic                  init_done
);

  import dffram_arb_pkg::*;

  localparam int BE = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_WORD = {ADDR_W{1'b1}};

  state_e              state_r;
  state_e              state_nxt;
  logic [ADDR_W-1:0]   cnt_r;
  logic                init_done_r;
  logic                rsp_valid_r;
  logic                rsp_tag_r;
  logic                serving_s;
  logic [1:0]          req_s;
  logic [1:0]          grant_s;

  assign serving_s = (state_r == ST_SERVE) && !rst;
  assign req_s     = {p1_valid, p0_valid} & {2{serving_s}};

  dffram_rr_arb u_rr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_s),
    .advance (serving_s),
    .grant   (grant_s)
  );

  assign p0_ready  = grant_s[0];
  assign p1_ready  = grant_s[1];
  assign init_done = init_done_r;

  // FSM next state: leave INIT once the last word is being cleared.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_INIT: begin
        if (cnt_r == LAST_WORD) begin
          state_nxt = ST_SERVE;
        end else begin
          state_nxt = ST_INIT;
        end
      end
      ST_SERVE: state_nxt = ST_SERVE;
      default:  state_nxt = ST_INIT;
    endcase
  end

  // RAM port mux: clear during INIT, granted requester during SERVE, idle zeros otherwise.
  always_comb begin
    ram_en = 1'b0;
    ram_we = {BE{1'b0}};
    ram_a  = {ADDR_W{1'b0}};
    ram_di = {DATA_W{1'b0}};
    if (rst) begin
      ram_en = 1'b0;
    end else if (state_r == ST_INIT) begin
      ram_en = 1'b1;
      ram_we = {BE{1'b1}};
      ram_a  = cnt_r;
    end else if (grant_s[0]) begin
      ram_en = 1'b1;
      ram_we = p0_we;
      ram_a  = p0_addr;
      ram_di = p0_wdata;
    end else if (grant_s[1]) begin
      ram_en = 1'b1;
      ram_we = p1_we;
      ram_a  = p1_addr;
      ram_di = p1_wdata;
    end else begin
      ram_en = 1'b0;
    end
  end

  // State, clear counter and response tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_INIT;
      cnt_r       <= {ADDR_W{1'b0}};
      init_done_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_tag_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      cnt_r       <= (state_r == ST_INIT) ? cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1} : cnt_r;
      init_done_r <= (state_nxt == ST_SERVE);
      rsp_valid_r <= |grant_s;
      rsp_tag_r   <= grant_s[1];
    end
  end

  // A reset in the response cycle suppresses that response as well.
  assign p0_rsp_valid = rsp_valid_r && !rsp_tag_r && !rst;
  assign p1_rsp_valid = rsp_valid_r &&  rsp_tag_r && !rst;
  assign p0_rsp_rdata = p0_rsp_valid ? ram_do : {DATA_W{1'b0}};
  assign p1_rsp_rdata = p1_rsp_valid ? ram_do : {DATA_W{1'b0}};

endmodule
